pwm_driver: RTL and testbench
=============================

# pwm_driver

Dual-channel PWM generator that consumes the 8-bit pump duty commands produced by the filter control FSM and drives the two pump power stages (pump A, pump B). Duty commands are sampled only at period boundaries, so outputs never glitch. Each channel's effective duty is slew-limited toward its commanded value, giving the pumps a soft start and soft stop.

## Interface

- `PRESCALE`, default 10: clocks per PWM phase step, valid range 1..65535. Period = 256*PRESCALE clocks; 2560 clocks gives about 19.5 kHz at 50 MHz.
- `RAMP_STEP`, default 4: maximum change of the effective duty per period, valid range 1..255. A value of 255 means no slew limiting.
- `clk`, input, 1: system clock.
- `reset`, input, 1: synchronous, active-high reset.
- `pwm_duty_a`, input, 8: commanded duty for pump A (0 = off, 255 = 255/256 on).
- `pwm_duty_b`, input, 8: commanded duty for pump B.
- `pwm_a`, output, 1: PWM drive for pump A.
- `pwm_b`, output, 1: PWM drive for pump B.
- `duty_eff_a`, output, 8: current effective (slewed) duty for pump A.
- `duty_eff_b`, output, 8: current effective (slewed) duty for pump B.
- `period_tick`, output, 1: one-cycle pulse on the cycle the effective duties update.
- `ramping`, output, 1: high while either effective duty differs from its latched target.

## Operation

- **Prescaler.** `pre_cnt` (16 bits) counts 0..PRESCALE-1 and wraps. The phase-advance condition is `adv = (pre_cnt == PRESCALE-1)`.
- **Phase counter.** `phase` (8 bits) increments on each `adv` and wraps from 255 to 0.
- **Period boundary.** `boundary = adv && phase == 255`. On that clock edge:
  - latch `tgt_a <= pwm_duty_a` and `tgt_b <= pwm_duty_b`;
  - update each effective duty toward the value just latched:
    - if `eff < tgt`: `eff <= min(eff + RAMP_STEP, tgt)`;
    - if `eff > tgt`: `eff <= max(eff - RAMP_STEP, tgt)`;
    - otherwise hold.
  - Compute in 9 bits so there is no wrap past 0 or 255, and never overshoot the target.
- **Mid-period commands.** Changes to `pwm_duty_x` between boundaries are ignored. Only the value present on the boundary cycle counts.
- **Ramp order.** Ramping is applied to the newly latched target on the same edge, so a new command starts moving on the first boundary after it appears.
- **Independent channels.** A and B ramp independently. The shared prescaler and phase keep both channels phase-aligned, with rising edges at phase 0.
- **Output comparison.** `pwm_x` is registered as `pwm_x <= (phase < eff_x)`, using the post-update values of `phase` and `eff_x`. The output is therefore aligned with the new phase and has no extra lag.
  - `eff = 0`: output constantly low.
  - `eff = 255`: output high for 255 of every 256 phase steps.
- **Status outputs.**
  - `ramping = (eff_a != tgt_a) || (eff_b != tgt_b)`, registered.
  - `period_tick` is registered and asserted for exactly the one cycle following each boundary edge.

## Timing

- **Reset (synchronous, priority over everything).** `pre_cnt`, `phase`, `tgt_x` and `eff_x` go to 0. `pwm_a`, `pwm_b`, `period_tick` and `ramping` go to 0. `duty_eff_x` reads 0.
- **Reset mid-period.** Outputs drop low on the edge where `reset` is sampled high. After release, the period restarts at `pre_cnt = 0`, `phase = 0`.
- **First boundary.** After reset release, the first boundary occurs 256*PRESCALE clocks later (on the edge ending cycle 256*PRESCALE-1).
- **Latency.** A command presented at a boundary first affects `pwm_x` on the same edge (the first phase-0 cycle). The full transition takes ceil(|Δ|/RAMP_STEP) periods.
- **High time.** Within a period, `pwm_x` is high for exactly `eff_x * PRESCALE` consecutive clocks, starting at phase 0.
- **Period length.** The period is exactly 256*PRESCALE clocks, with no jitter.
- **PRESCALE = 1.** `adv` is constantly high, so `phase` advances every clock.
- **Simultaneous events.** A duty change on the boundary cycle is taken. If reset and boundary coincide, reset wins.

## Test plan

- **No slew, PRESCALE=2.**
  - Stimulus: `RAMP_STEP=255`; `pwm_duty_a=77` and `pwm_duty_b=230` held before the first boundary.
  - Required response: in each subsequent 512-clock period, `pwm_a` is high 154 clocks and `pwm_b` is high 460 clocks; both rise on the same clock.
- **Soft start.**
  - Stimulus: `RAMP_STEP=32`; `pwm_duty_b` steps 0 → 230.
  - Required response: `duty_eff_b` over successive `period_tick`s is 32, 64, 96, 128, 160, 192, 224, 230. `ramping` is high until the 230 update and low afterwards.
- **Soft stop.**
  - Stimulus: `RAMP_STEP=32`; `pwm_duty_b` goes 230 → 77 after settling.
  - Required response: `duty_eff_b` is 198, 166, 134, 102, 77, with no undershoot below 77.
- **Mid-period change.**
  - Stimulus: `pwm_duty_a` toggles 77 → 0 → 77 entirely between two boundaries.
  - Required response: `pwm_a` pulse width is unchanged and `duty_eff_a` is unchanged.
- **Extremes.**
  - Stimulus: duty 0 held.
  - Required response: `pwm_x` never goes high.
  - Stimulus: duty 255 held with `RAMP_STEP=255`.
  - Required response: `pwm_x` is low for exactly PRESCALE clocks per period, at phase 255.
- **Reset mid-period.**
  - Stimulus: assert `reset` for 1 clock at phase 100 with `eff_a=230`.
  - Required response: on the next edge `pwm_a=0` and `duty_eff_a=0`. After release, the first `period_tick` arrives exactly 256*PRESCALE clocks later, and ramping restarts from 0.

Source files
------------

// File: rtl/pwm_driver.sv
// Dual-channel PWM driver for the pump power stages.
// Duty commands are taken only at period boundaries and each channel's
// effective duty is slewed toward its latched target by at most RAMP_STEP
// per period, giving the pumps a soft start and soft stop.
module pwm_driver #(
  parameter int unsigned PRESCALE  = 10,
  parameter int unsigned RAMP_STEP = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pwm_duty_a,
  input  logic [7:0] pwm_duty_b,
  output logic       pwm_a,
  output logic       pwm_b,
  output logic [7:0] duty_eff_a,
  output logic [7:0] duty_eff_b,
  output logic       period_tick,
  output logic       ramping
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DUTY_W = 8;
  localparam int unsigned CALC_W = 9;

  localparam logic [CNT_W-1:0]  PRE_LAST   = CNT_W'(PRESCALE - 1);
  localparam logic [CALC_W-1:0] STEP       = CALC_W'(RAMP_STEP);
  localparam logic [DUTY_W-1:0] PHASE_LAST = DUTY_W'(255);

  logic [CNT_W-1:0]  pre_cnt;
  logic [DUTY_W-1:0] phase;
  logic [DUTY_W-1:0] tgt_a;
  logic [DUTY_W-1:0] tgt_b;
  logic [DUTY_W-1:0] eff_a;
  logic [DUTY_W-1:0] eff_b;

  logic              adv;
  logic              boundary;
  logic [CNT_W-1:0]  pre_cnt_nxt;
  logic [DUTY_W-1:0] phase_nxt;
  logic [DUTY_W-1:0] tgt_a_nxt;
  logic [DUTY_W-1:0] tgt_b_nxt;
  logic [DUTY_W-1:0] eff_a_nxt;
  logic [DUTY_W-1:0] eff_b_nxt;

  // Move eff one slew step toward tgt; 9-bit math so nothing wraps and the
  // result never passes the target.
  function automatic logic [DUTY_W-1:0] slew(input logic [DUTY_W-1:0] eff,
                                             input logic [DUTY_W-1:0] tgt);
    logic [CALC_W-1:0] up;
    logic [CALC_W-1:0] floor_lim;
    up        = {1'b0, eff} + STEP;
    floor_lim = {1'b0, tgt} + STEP;
    if (eff < tgt) begin
      slew = (up > {1'b0, tgt}) ? tgt : up[DUTY_W-1:0];
    end else if (eff > tgt) begin
      slew = ({1'b0, eff} < floor_lim) ? tgt : eff - STEP[DUTY_W-1:0];
    end else begin
      slew = eff;
    end
  endfunction

  // Next-state for prescaler, phase, targets and effective duties.
  always_comb begin
    adv         = (pre_cnt == PRE_LAST);
    boundary    = adv && (phase == PHASE_LAST);
    pre_cnt_nxt = adv ? '0 : pre_cnt + CNT_W'(1);
    phase_nxt   = adv ? phase + DUTY_W'(1) : phase;
    tgt_a_nxt   = tgt_a;
    tgt_b_nxt   = tgt_b;
    eff_a_nxt   = eff_a;
    eff_b_nxt   = eff_b;
    if (boundary) begin
      tgt_a_nxt = pwm_duty_a;
      tgt_b_nxt = pwm_duty_b;
      eff_a_nxt = slew(eff_a, pwm_duty_a);
      eff_b_nxt = slew(eff_b, pwm_duty_b);
    end
  end

  // State and registered outputs, compared against post-update phase/duty.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt     <= '0;
      phase       <= '0;
      tgt_a       <= '0;
      tgt_b       <= '0;
      eff_a       <= '0;
      eff_b       <= '0;
      pwm_a       <= 1'b0;
      pwm_b       <= 1'b0;
      period_tick <= 1'b0;
      ramping     <= 1'b0;
    end else begin
      pre_cnt     <= pre_cnt_nxt;
      phase       <= phase_nxt;
      tgt_a       <= tgt_a_nxt;
      tgt_b       <= tgt_b_nxt;
      eff_a       <= eff_a_nxt;
      eff_b       <= eff_b_nxt;
      pwm_a       <= (phase_nxt < eff_a_nxt);
      pwm_b       <= (phase_nxt < eff_b_nxt);
      period_tick <= boundary;
      ramping     <= (eff_a_nxt != tgt_a_nxt) || (eff_b_nxt != tgt_b_nxt);
    end
  end

  assign duty_eff_a = eff_a;
  assign duty_eff_b = eff_b;

endmodule

// File: tb/tb_pwm_driver.sv
// Bench for pwm_driver: one fast unslewed instance (PRESCALE=2) and one
// slewed instance (PRESCALE=1, RAMP_STEP=32), both tracked every cycle by an
// arithmetic reference model, plus table and hand-written sequences.
module tb_pwm_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // fast instance: PRESCALE=2, RAMP_STEP=255
  logic       rst_f;
  logic [7:0] da_f, db_f;
  logic       pwm_a_f, pwm_b_f, tick_f, ramp_f;
  logic [7:0] eff_a_f, eff_b_f;

  // ramp instance: PRESCALE=1, RAMP_STEP=32
  logic       rst_r;
  logic [7:0] da_r, db_r;
  logic       pwm_a_r, pwm_b_r, tick_r, ramp_r;
  logic [7:0] eff_a_r, eff_b_r;

  pwm_driver #(.PRESCALE(2), .RAMP_STEP(255)) u_fast (
    .clk(clk), .reset(rst_f), .pwm_duty_a(da_f), .pwm_duty_b(db_f),
    .pwm_a(pwm_a_f), .pwm_b(pwm_b_f), .duty_eff_a(eff_a_f), .duty_eff_b(eff_b_f),
    .period_tick(tick_f), .ramping(ramp_f)
  );

  pwm_driver #(.PRESCALE(1), .RAMP_STEP(32)) u_ramp (
    .clk(clk), .reset(rst_r), .pwm_duty_a(da_r), .pwm_duty_b(db_r),
    .pwm_a(pwm_a_r), .pwm_b(pwm_b_r), .duty_eff_a(eff_a_r), .duty_eff_b(eff_b_r),
    .period_tick(tick_r), .ramping(ramp_r)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_n = clock edges since reset modulo the period length; boundary when it
  // returns to 0. Phase is m_n / PRESCALE.
  int m_n[2], m_ea[2], m_eb[2], m_ta[2], m_tb[2];
  bit m_tick[2], m_valid[2];
  localparam int P_F = 2, RS_F = 255, P_R = 1, RS_R = 32;

  function automatic int slew_m(input int e, input int t, input int rs);
    if (e < t) return (e + rs < t) ? e + rs : t;
    if (e > t) return (e - rs > t) ? e - rs : t;
    return e;
  endfunction

  task automatic model_step(input int i, input int p, input int rs,
                            input logic rst, input logic [7:0] da, input logic [7:0] db);
    if (rst) begin
      m_valid[i] = 1'b1;
      m_n[i] = 0; m_ea[i] = 0; m_eb[i] = 0; m_ta[i] = 0; m_tb[i] = 0; m_tick[i] = 1'b0;
    end else if (m_valid[i]) begin
      m_n[i]    = (m_n[i] + 1) % (256 * p);
      m_tick[i] = (m_n[i] == 0);
      if (m_tick[i]) begin
        m_ta[i] = int'(da);
        m_tb[i] = int'(db);
        m_ea[i] = slew_m(m_ea[i], m_ta[i], rs);
        m_eb[i] = slew_m(m_eb[i], m_tb[i], rs);
      end
    end
  endtask

  // Model advances on the same edge as the DUTs.
  always @(posedge clk) begin
    model_step(0, P_F, RS_F, rst_f, da_f, db_f);
    model_step(1, P_R, RS_R, rst_r, da_r, db_r);
  end

  // Compare every DUT output against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid[0]) begin
      check("fast_pwm_a", 16'(pwm_a_f), 16'((m_n[0] / P_F) < m_ea[0]));
      check("fast_pwm_b", 16'(pwm_b_f), 16'((m_n[0] / P_F) < m_eb[0]));
      check("fast_eff_a", 16'(eff_a_f), 16'(m_ea[0]));
      check("fast_eff_b", 16'(eff_b_f), 16'(m_eb[0]));
      check("fast_tick",  16'(tick_f),  16'(m_tick[0]));
      check("fast_ramp",  16'(ramp_f),  16'((m_ea[0] != m_ta[0]) || (m_eb[0] != m_tb[0])));
    end
    if (m_valid[1]) begin
      check("ramp_pwm_a", 16'(pwm_a_r), 16'((m_n[1] / P_R) < m_ea[1]));
      check("ramp_pwm_b", 16'(pwm_b_r), 16'((m_n[1] / P_R) < m_eb[1]));
      check("ramp_eff_a", 16'(eff_a_r), 16'(m_ea[1]));
      check("ramp_eff_b", 16'(eff_b_r), 16'(m_eb[1]));
      check("ramp_tick",  16'(tick_r),  16'(m_tick[1]));
      check("ramp_ramp",  16'(ramp_r),  16'((m_ea[1] != m_ta[1]) || (m_eb[1] != m_tb[1])));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_tick(input int idx, input int limit, output int cyc);
    logic t;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      t = (idx == 0) ? tick_f : tick_r;
    end while (t !== 1'b1 && cyc < limit);
    checks++;
    if (t !== 1'b1) begin
      errors++;
      $display("FAIL tick_timeout[%0d]: got no period_tick within %0d cycles", idx, limit);
    end
  endtask

  // Count fast-instance high clocks over one 512-clock period starting at a tick cycle.
  task automatic count_period(output int ha, output int hb, output logic rise_same,
                              output logic tail_b_low, input logic mid_toggle);
    ha = 0; hb = 0; rise_same = 1'b0; tail_b_low = 1'b1;
    for (int i = 0; i < 512; i++) begin
      if (pwm_a_f === 1'b1) ha++;
      if (pwm_b_f === 1'b1) hb++;
      if (i == 0) rise_same = (pwm_a_f === pwm_b_f);
      if (i >= 510 && pwm_b_f !== 1'b0) tail_b_low = 1'b0;
      if (mid_toggle && i == 100) da_f = 8'd0;
      if (mid_toggle && i == 300) da_f = 8'd77;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] da;
    logic [7:0] db;
    logic [7:0] ea;
    logic [7:0] eb;
    logic       rmp;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int cyc, ha, hb;
    logic rise_same, tail_low;

    tbl[0]  = '{8'd50, 8'd230, 8'd32, 8'd32,  1'b1};
    tbl[1]  = '{8'd50, 8'd230, 8'd50, 8'd64,  1'b1};
    tbl[2]  = '{8'd50, 8'd230, 8'd50, 8'd96,  1'b1};
    tbl[3]  = '{8'd50, 8'd230, 8'd50, 8'd128, 1'b1};
    tbl[4]  = '{8'd50, 8'd230, 8'd50, 8'd160, 1'b1};
    tbl[5]  = '{8'd50, 8'd230, 8'd50, 8'd192, 1'b1};
    tbl[6]  = '{8'd50, 8'd230, 8'd50, 8'd224, 1'b1};
    tbl[7]  = '{8'd50, 8'd230, 8'd50, 8'd230, 1'b0};
    tbl[8]  = '{8'd50, 8'd77,  8'd50, 8'd198, 1'b1};
    tbl[9]  = '{8'd50, 8'd77,  8'd50, 8'd166, 1'b1};
    tbl[10] = '{8'd50, 8'd77,  8'd50, 8'd134, 1'b1};
    tbl[11] = '{8'd50, 8'd77,  8'd50, 8'd102, 1'b1};
    tbl[12] = '{8'd50, 8'd77,  8'd50, 8'd77,  1'b0};
    tbl[13] = '{8'd0,  8'd77,  8'd18, 8'd77,  1'b1};
    tbl[14] = '{8'd0,  8'd77,  8'd0,  8'd77,  1'b0};

    rst_f = 1'b1; da_f = 8'd77; db_f = 8'd230;
    rst_r = 1'b1; da_r = 8'd0;  db_r = 8'd0;
    repeat (4) @(negedge clk);

    // reset state
    check("rst_pwm_a", 16'(pwm_a_f), 16'd0);
    check("rst_eff_b", 16'(eff_b_f), 16'd0);
    check("rst_tick",  16'(tick_f),  16'd0);
    check("rst_ramp",  16'(ramp_f),  16'd0);

    // no slew, PRESCALE=2: first boundary timing and high times
    rst_f = 1'b0;
    wait_tick(0, 1000, cyc);
    check("first_tick_cycles", 16'(cyc), 16'd512);
    check("nos_eff_a", 16'(eff_a_f), 16'd77);
    count_period(ha, hb, rise_same, tail_low, 1'b0);
    check("nos_high_a", 16'(ha), 16'd154);
    check("nos_high_b", 16'(hb), 16'd460);
    check("nos_rise_same", 16'(rise_same && pwm_a_f !== 1'bx), 16'd1);
    check("period_len_tick", 16'(tick_f), 16'd1);

    // mid-period toggle of pwm_duty_a is ignored
    count_period(ha, hb, rise_same, tail_low, 1'b1);
    check("mid_high_a", 16'(ha), 16'd154);
    check("mid_eff_a", 16'(eff_a_f), 16'd77);
    check("mid_tick", 16'(tick_f), 16'd1);
    da_f = 8'd0; db_f = 8'd255;
    count_period(ha, hb, rise_same, tail_low, 1'b0);
    check("mid_next_high_a", 16'(ha), 16'd154);

    // extremes: duty 0 never high, duty 255 low only at phase 255
    count_period(ha, hb, rise_same, tail_low, 1'b0);
    check("ext_high_a0", 16'(ha), 16'd0);
    check("ext_high_b255", 16'(hb), 16'd510);
    check("ext_tail_low", 16'(tail_low), 16'd1);

    // reset mid-period on the fast instance
    da_f = 8'd230;
    wait_tick(0, 600, cyc);
    check("pre_rst_tick_cycles", 16'(cyc), 16'd512);
    check("pre_rst_eff_a", 16'(eff_a_f), 16'd230);
    repeat (200) @(negedge clk);
    check("phase100_pwm_a", 16'(pwm_a_f), 16'd1);
    rst_f = 1'b1;
    @(negedge clk);
    check("midrst_pwm_a", 16'(pwm_a_f), 16'd0);
    check("midrst_eff_a", 16'(eff_a_f), 16'd0);
    rst_f = 1'b0;
    wait_tick(0, 1000, cyc);
    check("midrst_tick_cycles", 16'(cyc), 16'd512);

    // soft start / soft stop on the slewed instance, table driven
    rst_r = 1'b0;
    for (int k = 0; k < 15; k++) begin
      da_r = tbl[k].da;
      db_r = tbl[k].db;
      wait_tick(1, 400, cyc);
      check($sformatf("tbl%0d_cycles", k), 16'(cyc), 16'd256);
      check($sformatf("tbl%0d_eff_a", k), 16'(eff_a_r), 16'(tbl[k].ea));
      check($sformatf("tbl%0d_eff_b", k), 16'(eff_b_r), 16'(tbl[k].eb));
      check($sformatf("tbl%0d_ramp", k), 16'(ramp_r), 16'(tbl[k].rmp));
    end

    // randomized traffic on both instances, judged by the model
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) da_r = 8'($urandom);
      if ($urandom_range(0, 199) == 0) db_r = 8'($urandom);
      if ($urandom_range(0, 299) == 0) da_f = 8'($urandom);
      if ($urandom_range(0, 299) == 0) db_f = 8'($urandom);
      rst_r = ($urandom_range(0, 2999) == 0);
      rst_f = ($urandom_range(0, 3999) == 0);
    end
    rst_r = 1'b0; rst_f = 1'b0;

    // reset mid-period on the slewed instance: ramp restarts from 0
    da_r = 8'd0; db_r = 8'd77;
    repeat (37) @(negedge clk);
    rst_r = 1'b1;
    @(negedge clk);
    check("r_midrst_eff_b", 16'(eff_b_r), 16'd0);
    check("r_midrst_pwm_b", 16'(pwm_b_r), 16'd0);
    rst_r = 1'b0;
    wait_tick(1, 400, cyc);
    check("r_midrst_tick_cycles", 16'(cyc), 16'd256);
    check("r_restart_eff_b", 16'(eff_b_r), 16'd32);
    check("r_restart_ramp", 16'(ramp_r), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
